// File: rtl/store_write_buffer.sv
// Store write buffer between the M-stage request and the data memory port: FIFO of
// byte-enabled stores, load priority on DM, load stall on word-address hit.
// Optional macro WB_COALESCE_EN merges a store into the tail entry when the word matches.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    input  logic        dm_ready,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_pc,
    output logic        wb_empty
);

    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic [29:0]      ent_waddr [DEPTH];
    logic [31:0]      ent_data  [DEPTH];
    logic [3:0]       ent_be    [DEPTH];
    logic [31:0]      ent_pc    [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic             is_load;
    logic             is_store;
    logic             load_hit;
    logic             load_go;
    logic             drain;
    logic             full;
    logic             coalesce;
    logic             alloc;

    assign is_load  = req_valid & ~req_we;
    assign is_store = req_valid & req_we;
    assign full     = (count == FULL_CNT);

    // An entry is occupied when its distance from the head is below count.
    always_comb begin
        load_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offs;
            offs = PTR_W'(i) - rd_ptr;
            if (({1'b0, offs} < count) && (ent_waddr[i] == req_addr[31:2]))
                load_hit = 1'b1;
        end
    end

    assign load_go = is_load & ~load_hit;
    assign drain   = (count != '0) & ~load_go & dm_ready;

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] tail_ptr;
    assign tail_ptr = wr_ptr - PTR_ONE;
    // A lone entry that is leaving this cycle cannot absorb the store.
    assign coalesce = is_store & (count != '0) & (ent_waddr[tail_ptr] == req_addr[31:2])
                    & ~((count == CNT_ONE) & drain);
`else
    assign coalesce = 1'b0;
`endif

    assign alloc = is_store & ~full & ~coalesce;

    always_comb begin
        req_ready = 1'b1;
        if (is_store)
            req_ready = ~full | coalesce;
        else if (is_load)
            req_ready = ~load_hit;
    end

    assign dm_we    = drain;
    assign dm_addr  = load_go ? req_addr : {ent_waddr[rd_ptr], 2'b00};
    assign dm_wdata = ent_data[rd_ptr];
    assign dm_be    = ent_be[rd_ptr];
    assign dm_pc    = ent_pc[rd_ptr];
    assign wb_empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (alloc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (drain)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({alloc, drain})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry payload carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_waddr[wr_ptr] <= req_addr[31:2];
            ent_data[wr_ptr]  <= req_wdata;
            ent_be[wr_ptr]    <= req_be;
            ent_pc[wr_ptr]    <= req_pc;
        end
`ifdef WB_COALESCE_EN
        if (coalesce) begin
            for (int b = 0; b < 4; b++)
                if (req_be[b])
                    ent_data[tail_ptr][8*b +: 8] <= req_wdata[8*b +: 8];
            ent_be[tail_ptr] <= ent_be[tail_ptr] | req_be;
            ent_pc[tail_ptr] <= req_pc;
        end
`endif
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized bench for store_write_buffer against a queue-based model of the buffer.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
`ifdef WB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic [3:0]  req_be;
    logic        req_ready, dm_ready, dm_we, wb_empty;
    logic [31:0] dm_addr, dm_wdata, dm_pc;
    logic [3:0]  dm_be;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc;
    } ent_t;
    ent_t q[$];
    bit   last_ready;

    store_write_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_pc(req_pc),
        .req_ready(req_ready), .dm_ready(dm_ready), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_pc(dm_pc), .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare with model, update model for the edge.
    task automatic cyc(input bit rst, input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input bit dmr);
        bit hit, ld_go, drn, coal, acc;
        logic [31:0] pc;
        pc = 32'h1000 + 32'(n_checks);
        reset = rst; req_valid = v; req_we = we; req_addr = a;
        req_wdata = d; req_be = be; req_pc = pc; dm_ready = dmr;
        #1;
        hit = 1'b0;
        foreach (q[i]) if (q[i].waddr == a[31:2]) hit = 1'b1;
        ld_go = v && !we && !hit;
        drn   = (q.size() != 0) && !ld_go && dmr;
        coal  = COAL && v && we && q.size() != 0 && q[$].waddr == a[31:2]
                && !(q.size() == 1 && drn);
        if (v && we) acc = (q.size() < DEPTH) || coal;
        else if (v)  acc = !hit;
        else         acc = 1'b1;
        last_ready = acc;
        check("req_ready", 32'(req_ready), 32'(acc));
        check("dm_we", 32'(dm_we), 32'(drn));
        check("wb_empty", 32'(wb_empty), 32'(q.size() == 0));
        if (ld_go) check("dm_addr_load", dm_addr, a);
        if (drn) begin
            check("dm_addr_store", dm_addr, {q[0].waddr, 2'b00});
            check("dm_wdata", dm_wdata, q[0].data);
            check("dm_be", 32'(dm_be), 32'(q[0].be));
            check("dm_pc", dm_pc, q[0].pc);
        end
        if (rst) begin
            q.delete();
        end else begin
            if (coal) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) q[$].data[8*b +: 8] = d[8*b +: 8];
                q[$].be = q[$].be | be;
                q[$].pc = pc;
            end
            if (drn) void'(q.pop_front());
            if (v && we && acc && !coal)
                q.push_back('{waddr: a[31:2], data: d, be: be, pc: pc});
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit dmr);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, dmr);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; req_pc = '0; dm_ready = 1'b0;
        @(negedge clk);
        do_reset();
        check("reset_dm_we", 32'(dm_we), 32'd0);
        check("reset_wb_empty", 32'(wb_empty), 32'd1);

        // Single store drains one cycle after acceptance.
        cyc(1'b0, 1'b1, 1'b1, 32'h10, 32'h11223344, 4'hF, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill with DM blocked; fifth store waits for space.
        for (int k = 0; k < 5; k++)
            cyc(1'b0, 1'b1, 1'b1, 32'(4 * k), 32'hA0 + 32'(k), 4'hF, 1'b0);
        check("fifth_stalled", 32'(last_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'h10, 32'hA4, 4'hF, 1'b1);
            if (last_ready) break;
        end
        check("fifth_accepted", 32'(last_ready), 32'd1);
        repeat (6) idle(1'b1);

        // Load hitting a pending store stalls until it drains.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'h20, 32'h5555AAAA, 4'hF, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1);
        check("hit_load_done", 32'(last_ready), 32'd1);

        // Load to another word wins the port; store drains next cycle.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1);
        idle(1'b1);

        // Simultaneous accept and drain, then reset with entries queued.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'h50, 32'h1, 4'hF, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h54, 32'h2, 4'hF, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h58, 32'h3, 4'hF, 1'b1);
        check("count_two", 32'(q.size()), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        idle(1'b1);

`ifdef WB_COALESCE_EN
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'h31, 32'h0000AA00, 4'h2, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h33, 32'hBB000000, 4'h8, 1'b0);
        check("coal_count", 32'(q.size()), 32'd1);
        check("coal_be_model", 32'(q[0].be), 32'hA);
        check("coal_data_model", q[0].data, 32'hBB00AA00);
        idle(1'b1);
`endif

        // Randomized traffic over a small set of words to provoke hits and merges.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] a;
            a = {25'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 1), a, $urandom,
                4'($urandom_range(1, 15)), ($urandom_range(0, 2) != 0));
        end
        repeat (8) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
